// File: rtl/stim_resp_checker_if.sv
// rtl/stim_resp_checker_if.sv - stimulus/response and status bundle for stim_resp_checker
interface stim_resp_checker_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             c_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [1:0]       fail_idx;

  // slave: the checker itself; master: whoever starts it and closes the loop through "top"
  modport slave (
    input  start, c_in,
    output a_out, b_out, busy, done, pass, err_cnt, fail_valid, fail_idx
  );

  modport master (
    output start, c_in,
    input  a_out, b_out, busy, done, pass, err_cnt, fail_valid, fail_idx
  );
endinterface

// File: rtl/stim_resp_checker.sv
// rtl/stim_resp_checker.sv - self-running 4-step stimulus/response checker for a 2-in/1-out block
module stim_resp_checker #(
  parameter logic [3:0] EXP_TT     = 4'b1000,
  parameter int         SETTLE_CYC = 10,
  parameter int         ERR_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  stim_resp_checker_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       k_q, k_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [1:0]       fi_q, fi_d;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fi_q    <= fi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fi_d     = fi_q;
    // Case inequality so an unknown response is never taken as a match
    mismatch = (bus.c_in !== EXP_TT[k_q]);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = APPLY;
          cnt_d   = '0;
          k_d     = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          fi_d    = 2'd0;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(SETTLE_CYC)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fv_q) begin
            fv_d = 1'b1;
            fi_d = k_q;
          end
        end
        if (k_q == 2'd3) begin
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          // Step k drives a=k[0], b=k[1]: 00,10,01,11
          k_d     = k_q + 2'd1;
          a_d     = k_d[0];
          b_d     = k_d[1];
          cnt_d   = '0;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.busy       = (state_q == APPLY) || (state_q == CHECK);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = (state_q == DONE) && (err_q == '0);
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_idx   = fi_q;

endmodule

// File: tb/tb_stim_resp_checker.sv
// tb/tb_stim_resp_checker.sv - directed table-driven bench for stim_resp_checker
module tb_stim_resp_checker;

  logic clk;
  logic rst_n;
  int   mode;
  int   n_checks;
  int   n_fail;

  stim_resp_checker_if #(.ERR_W(4)) bus ();
  stim_resp_checker_if #(.ERR_W(1)) bus1 ();

  stim_resp_checker #(.EXP_TT(4'b1000), .SETTLE_CYC(10), .ERR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  stim_resp_checker #(.EXP_TT(4'b1000), .SETTLE_CYC(10), .ERR_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the block under check, selectable per vector
  logic c_model;
  always_comb begin
    case (mode)
      1:       c_model = bus.a_out | bus.b_out;
      2:       c_model = 1'b1;
      3:       c_model = 1'b0;
      4:       c_model = bus.a_out ^ bus.b_out;
      5:       c_model = ~(bus.a_out & bus.b_out);
      default: c_model = bus.a_out & bus.b_out;
    endcase
  end
  assign bus.c_in  = c_model;
  assign bus1.c_in = 1'b1;

  typedef struct {
    int         mode;
    bit         extra_start;
    logic [3:0] exp_err;
    logic       exp_fv;
    logic [1:0] exp_fi;
    logic       exp_pass;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},    bus.a_out, 0);
    check({tag, "_b"},    bus.b_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_pass"}, bus.pass, 0);
    check({tag, "_err"},  bus.err_cnt, 0);
    check({tag, "_fv"},   bus.fail_valid, 0);
    check({tag, "_fi"},   bus.fail_idx, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         bad;
    logic [1:0] step;
    mode = v.mode;
    bad  = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("v%0d_start_err_clr", idx), bus.err_cnt, 0);
    check($sformatf("v%0d_start_fv_clr", idx), bus.fail_valid, 0);
    for (int n = 1; n <= 44; n++) begin
      if (n > 1) @(negedge clk);
      step = 2'((n - 1) / 11);
      if (bus.a_out !== step[0] || bus.b_out !== step[1] ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      bus.start = v.extra_start && (n == 5 || n == 20);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("v%0d_seq_bad_cycles", idx), bad, 0);
    check($sformatf("v%0d_done", idx), bus.done, 1);
    check($sformatf("v%0d_busy", idx), bus.busy, 0);
    check($sformatf("v%0d_ab_done", idx), {bus.a_out, bus.b_out}, 0);
    check($sformatf("v%0d_err", idx), bus.err_cnt, v.exp_err);
    check($sformatf("v%0d_fv", idx), bus.fail_valid, v.exp_fv);
    check($sformatf("v%0d_fi", idx), bus.fail_idx, v.exp_fi);
    check($sformatf("v%0d_pass", idx), bus.pass, v.exp_pass);
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_err_stable", idx), bus.err_cnt, v.exp_err);
  endtask

  initial begin
    int bad;
    n_checks   = 0;
    n_fail     = 0;
    mode       = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus1.start = 1'b0;

    vecs[0] = '{0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1};
    vecs[1] = '{1, 1'b0, 4'd2, 1'b1, 2'd1, 1'b0};
    vecs[2] = '{0, 1'b1, 4'd0, 1'b0, 2'd0, 1'b1};
    vecs[3] = '{2, 1'b0, 4'd3, 1'b1, 2'd0, 1'b0};
    vecs[4] = '{3, 1'b0, 4'd1, 1'b1, 2'd3, 1'b0};
    vecs[5] = '{4, 1'b0, 4'd3, 1'b1, 2'd1, 1'b0};
    vecs[6] = '{5, 1'b0, 4'd4, 1'b1, 2'd0, 1'b0};
    vecs[7] = '{1, 1'b1, 4'd2, 1'b1, 2'd1, 1'b0};

    // Reset, then idle without start
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.a_out !== 1'b0 || bus.b_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);
    check_all_zero("idle");

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Async reset during step 2 APPLY of an OR run
    mode = 1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    check("mid_err_pre", bus.err_cnt, 1);
    check("mid_fv_pre", bus.fail_valid, 1);
    check("mid_ab_pre", {bus.a_out, bus.b_out}, 2'b01);
    check("mid_busy_pre", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.a_out !== 1'b0 || bus.b_out !== 1'b0) bad++;
    end
    check("post_rst_idle_bad", bad, 0);
    check_all_zero("post_rst");
    run_vec(vecs[0], 8);

    // Saturating counter with ERR_W=1 and c_in stuck high
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (44) @(negedge clk);
    check("sat_done", bus1.done, 1);
    check("sat_err", bus1.err_cnt, 1);
    check("sat_fv", bus1.fail_valid, 1);
    check("sat_fi", bus1.fail_idx, 0);
    check("sat_pass", bus1.pass, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
